// File: rtl/radiant_trig_coinc_if.sv
// ----------------------------------------------------------------------------
// radiant_trig_coinc_if
// This is the 32-bit wishbone classic bus used to configure radiant_trig_coinc.
//
// Signals:
//   cyc, stb, we   master -> slave   bus strobes
//   adr   [7:0]    master -> slave   byte address (bits [1:0] are ignored)
//   dat_w [31:0]   master -> slave   write data (full words only)
//   sel   [3:0]    master -> slave   byte selects (ignored by the slave)
//   dat_r [31:0]   slave -> master   read data, valid while ack is high
//   ack            slave -> master   single-cycle acknowledge
//   err, rty       slave -> master   always 0
// ----------------------------------------------------------------------------
interface radiant_trig_coinc_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/radiant_trig_coinc.sv
// ----------------------------------------------------------------------------
// radiant_trig_coinc
// This is an N-channel trigger front-end. It sits between the trigger input
// buffers and event control.
//
// Each channel goes through these steps:
//   1. polarity fix
//   2. rising-edge detect
//   3. mask
//   4. retriggerable stretcher
// An M-of-N majority coincidence then drives a fire/holdoff FSM, which
// produces a one-cycle trig_o pulse.
//
// Optional macro: RADIANT_TRIG_SCALER_EN
//   When defined, the design adds one saturating scaler per channel, each
//   with a latched shadow copy.
//
// Ports:
//   clk_i        single clock for all logic
//   rst_ni       asynchronous active-low reset
//   wb           wishbone slave (radiant_trig_coinc_if.slave)
//   trig_i       trigger bits, already synchronous to clk_i
//   stretched_o  stretched, masked channel flags (debug)
//   trig_o       one-cycle trigger pulse
//
// Register map (byte addresses):
//   0x00 CTRL        [0] ENABLE, [1] FORCE (write-1 pulse, reads 0),
//                    [15:8] HOLDOFF, [20:16] MAJ
//   0x04 MASK        [NUM_CH-1:0]
//   0x08 STRETCH     [STRETCH_W-1:0]
//   0x0C TRIGCNT     fire count; wraps; any write clears it
//   0x10 SCAL_LATCH  a write copies the live scalers to the shadows
//   0x80+4*i         scaler shadow i
// ----------------------------------------------------------------------------
module radiant_trig_coinc #(
    parameter int                NUM_CH        = 24,
    parameter logic [NUM_CH-1:0] TRIG_POLARITY = '0,
    parameter int                STRETCH_W     = 4,
    parameter int                HOLDOFF_W     = 8,
    parameter int                SCALER_W      = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    radiant_trig_coinc_if.slave wb,
    input  logic [NUM_CH-1:0]   trig_i,
    output logic [NUM_CH-1:0]   stretched_o,
    output logic                trig_o
);

    localparam logic [5:0] W_CTRL    = 6'h00;
    localparam logic [5:0] W_MASK    = 6'h01;
    localparam logic [5:0] W_STRETCH = 6'h02;
    localparam logic [5:0] W_TRIGCNT = 6'h03;
    localparam logic [5:0] W_SLATCH  = 6'h04;

    // ------------------------------------------------------------------
    // Wishbone slave
    // ------------------------------------------------------------------
    logic                 wb_req;
    logic                 wb_wr;
    logic [5:0]           word;
    logic [31:0]          rdata;

    logic                 enable_r;
    logic                 force_q;
    logic [HOLDOFF_W-1:0] holdoff_r;
    logic [4:0]           maj_r;
    logic [NUM_CH-1:0]    mask_r;
    logic [STRETCH_W-1:0] stretch_r;
    logic [31:0]          trigcnt_r;
    logic                 fire_go;

    // Requiring ~ack makes every transfer take two cycles, so ack can never
    // be asserted on two consecutive cycles.
    assign wb_req = wb.cyc & wb.stb & ~wb.ack;
    assign wb_wr  = wb_req & wb.we;
    assign word   = wb.adr[7:2];
    assign wb.err = 1'b0;
    assign wb.rty = 1'b0;

    // These bits are not decoded. Reducing them into one net keeps lint quiet.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{wb.sel, wb.adr[1:0], wb.dat_w};

`ifdef RADIANT_TRIG_SCALER_EN
    logic [SCALER_W-1:0] scal_live   [NUM_CH];
    logic [SCALER_W-1:0] scal_shadow [NUM_CH];
`endif

    always_comb begin
        rdata = '0;
        case (word)
            W_CTRL: begin
                rdata[0]     = enable_r;
                rdata[15:8]  = 8'(holdoff_r);
                rdata[20:16] = maj_r;
            end
            W_MASK:    rdata = 32'(mask_r);
            W_STRETCH: rdata = 32'(stretch_r);
            W_TRIGCNT: rdata = trigcnt_r;
            default: begin
`ifdef RADIANT_TRIG_SCALER_EN
                if (word[5]) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (word[4:0] == 5'(i)) begin
                            rdata = 32'(scal_shadow[i]);
                        end
                    end
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb.ack   <= 1'b0;
            wb.dat_r <= '0;
        end else begin
            wb.ack   <= wb_req;
            wb.dat_r <= wb_req ? rdata : 32'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_r  <= 1'b0;
            force_q   <= 1'b0;
            holdoff_r <= '0;
            maj_r     <= 5'd1;
            mask_r    <= '1;
            stretch_r <= '0;
        end else begin
            force_q <= 1'b0;
            if (wb_wr) begin
                case (word)
                    W_CTRL: begin
                        enable_r  <= wb.dat_w[0];
                        force_q   <= wb.dat_w[1];
                        holdoff_r <= wb.dat_w[8 +: HOLDOFF_W];
                        maj_r     <= wb.dat_w[20:16];
                    end
                    W_MASK:    mask_r    <= wb.dat_w[NUM_CH-1:0];
                    W_STRETCH: stretch_r <= wb.dat_w[STRETCH_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // When a clear write lands in the same cycle as a fire, the clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trigcnt_r <= '0;
        end else if (wb_wr && word == W_TRIGCNT) begin
            trigcnt_r <= '0;
        end else if (fire_go) begin
            trigcnt_r <= trigcnt_r + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // S1: polarity, edge detect, mask, retriggerable stretcher
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]    pol;
    logic [NUM_CH-1:0]    pol_d;
    logic [NUM_CH-1:0]    rise;
    logic [NUM_CH-1:0]    live_edge;
    logic [NUM_CH-1:0]    act;
    logic [STRETCH_W-1:0] scnt [NUM_CH];

    assign pol         = trig_i ^ TRIG_POLARITY;
    assign rise        = pol & ~pol_d;
    assign live_edge   = rise & mask_r;
    assign stretched_o = act;

    // A channel stays active while its counter counts STRETCH down to 0,
    // which lasts STRETCH+1 cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pol_d <= '0;
            act   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                scnt[i] <= '0;
            end
        end else begin
            pol_d <= pol;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!mask_r[i]) begin
                    act[i] <= 1'b0;
                end else if (rise[i]) begin
                    act[i]  <= 1'b1;
                    scnt[i] <= stretch_r;
                end else if (act[i]) begin
                    if (scnt[i] == '0) begin
                        act[i] <= 1'b0;
                    end else begin
                        scnt[i] <= scnt[i] - STRETCH_W'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: registered popcount and coincidence
    // ------------------------------------------------------------------
    logic [5:0] act_sum;
    logic [5:0] count_q;
    logic       force_p;
    logic       coinc;
    logic       coinc_q;

    always_comb begin
        act_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            act_sum = act_sum + 6'(act[i]);
        end
    end

    // FORCE goes through the same number of stages as a channel edge. That
    // way a forced trigger has the same latency as a real one.
    assign coinc = ((maj_r != 5'd0) && (count_q >= {1'b0, maj_r})) || force_p;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            force_p <= 1'b0;
            coinc_q <= 1'b0;
        end else begin
            count_q <= act_sum;
            force_p <= force_q;
            coinc_q <= coinc;
        end
    end

    // ------------------------------------------------------------------
    // S3: fire / holdoff FSM
    //   state   | meaning
    //   IDLE    | waiting for a coincidence while ENABLE is set
    //   FIRE    | trig_o high for this one cycle
    //   HOLDOFF | counting HOLDOFF cycles; coincidences are dropped
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t               state;
    logic [HOLDOFF_W-1:0] hcnt;

    assign fire_go = enable_r && (state == IDLE) && coinc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            trig_o <= 1'b0;
            hcnt   <= '0;
        end else if (!enable_r) begin
            state  <= IDLE;
            trig_o <= 1'b0;
            hcnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    trig_o <= 1'b0;
                    if (coinc_q) begin
                        state  <= FIRE;
                        trig_o <= 1'b1;
                    end
                end
                FIRE: begin
                    trig_o <= 1'b0;
                    if (holdoff_r == '0) begin
                        state <= IDLE;
                    end else begin
                        state <= HOLDOFF;
                        hcnt  <= holdoff_r - HOLDOFF_W'(1);
                    end
                end
                HOLDOFF: begin
                    trig_o <= 1'b0;
                    if (hcnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hcnt <= hcnt - HOLDOFF_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    trig_o <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional per-channel rate scalers
    // ------------------------------------------------------------------
`ifdef RADIANT_TRIG_SCALER_EN
    logic scal_latch;
    assign scal_latch = wb_wr && (word == W_SLATCH);

    // On a latch, an edge arriving in the same cycle starts the new interval
    // at 1 instead of being lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CH; i++) begin
                scal_live[i]   <= '0;
                scal_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (scal_latch) begin
                    scal_shadow[i] <= scal_live[i];
                    scal_live[i]   <= live_edge[i] ? SCALER_W'(1) : '0;
                end else if (live_edge[i] && (scal_live[i] != '1)) begin
                    scal_live[i] <= scal_live[i] + SCALER_W'(1);
                end
            end
        end
    end
`else
    logic unused_scaler_bits;
    assign unused_scaler_bits = ^live_edge;
`endif

endmodule

// File: tb/tb_radiant_trig_coinc.sv
// ----------------------------------------------------------------------------
// tb_radiant_trig_coinc
// This is a directed bench for radiant_trig_coinc with NUM_CH = 24.
// "Cycle c" means the clock period that follows the edge which samples the
// c-th step's trig value. Outputs are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_radiant_trig_coinc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] trig;
    logic [23:0] stretched;
    logic        trig_o;

    int total = 0;
    int bad   = 0;

    radiant_trig_coinc_if wb_if ();

    radiant_trig_coinc #(.NUM_CH(24)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wb          (wb_if),
        .trig_i      (trig),
        .stretched_o (stretched),
        .trig_o      (trig_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [23:0] t);
        trig = t;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                           output logic [31:0] q);
        logic got;
        got = 1'b0;
        q   = '0;
        trig = '0;
        wb_if.cyc   = 1'b1;
        wb_if.stb   = 1'b1;
        wb_if.we    = w;
        wb_if.adr   = a;
        wb_if.dat_w = d;
        wb_if.sel   = 4'hF;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            got = wb_if.ack;
            if (got) q = wb_if.dat_r;
        end
        wb_if.cyc = 1'b0;
        wb_if.stb = 1'b0;
        wb_if.we  = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $error("FAIL wb_timeout: observed=no_ack expected=ack addr=0x%02h", a);
        end
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, dummy);
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'd0, q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          pulses;

        rst_n       = 1'b1;
        trig        = '0;
        wb_if.cyc   = 1'b0;
        wb_if.stb   = 1'b0;
        wb_if.we    = 1'b0;
        wb_if.adr   = '0;
        wb_if.dat_w = '0;
        wb_if.sel   = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_trig_o", 32'(trig_o), 32'd0);
        chk("rst_stretched", 32'(stretched), 32'd0);
        chk("rst_ack", 32'(wb_if.ack), 32'd0);
        chk("rst_dat", wb_if.dat_r, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        wb_read(8'h00, rd);  chk("rst_ctrl", rd, 32'h0001_0000);
        @(posedge clk); #1;
        chk("ack_drops", 32'(wb_if.ack), 32'd0);
        wb_read(8'h04, rd);  chk("rst_mask", rd, 32'h00FF_FFFF);
        wb_read(8'h08, rd);  chk("rst_stretch", rd, 32'd0);
        wb_read(8'h0C, rd);  chk("rst_trigcnt", rd, 32'd0);
        wb_write(8'h40, 32'hFFFF_FFFF);
        wb_read(8'h40, rd);  chk("unmapped_rd", rd, 32'd0);
        wb_read(8'h04, rd);  chk("unmapped_wr_ignored", rd, 32'h00FF_FFFF);

        // Scalers: 7 edges on ch2, latch, then latch again with no edges
        for (int i = 0; i < 7; i++) begin
            step(24'h4);
            step(24'h0);
        end
        wb_write(8'h10, 32'd0);
        wb_read(8'h88, rd);
`ifdef RADIANT_TRIG_SCALER_EN
        chk("scaler_7", rd, 32'd7);
`else
        chk("scaler_absent", rd, 32'd0);
`endif
        wb_write(8'h10, 32'd0);
        wb_read(8'h88, rd);  chk("scaler_relatch", rd, 32'd0);

        // MAJ=2, STRETCH=3: ch0 at c0 and ch5 at c2 overlap -> fire at c5
        wb_write(8'h08, 32'd3);
        wb_write(8'h00, 32'h0002_0001);
        for (int c = 0; c < 13; c++) begin
            step(c == 0 ? 24'h1 : (c == 2 ? 24'h20 : 24'h0));
            chk($sformatf("win_in_c%0d", c), 32'(trig_o), 32'(c == 5));
        end
        wb_read(8'h0C, rd);  chk("trigcnt_1", rd, 32'd1);

        // Same setup, but ch5 at c4 is outside the window
        wb_write(8'h0C, 32'd0);
        wb_read(8'h0C, rd);  chk("trigcnt_clr", rd, 32'd0);
        for (int c = 0; c < 13; c++) begin
            step(c == 0 ? 24'h1 : (c == 4 ? 24'h20 : 24'h0));
            chk($sformatf("win_out_c%0d", c), 32'(trig_o), 32'd0);
        end
        wb_read(8'h0C, rd);  chk("trigcnt_0", rd, 32'd0);

        // MAJ=1, HOLDOFF=10, STRETCH=0: ch3 every 4 cycles -> fires 12 apart
        wb_write(8'h08, 32'd0);
        wb_write(8'h00, 32'h0001_0A01);
        pulses = 0;
        for (int c = 0; c < 44; c++) begin
            step((c % 4 == 0 && c < 40) ? 24'h8 : 24'h0);
            if (trig_o) pulses++;
            chk($sformatf("holdoff_c%0d", c), 32'(trig_o),
                32'(c == 3 || c == 15 || c == 27 || c == 39));
        end
        chk("holdoff_pulses", 32'(pulses), 32'd4);
        repeat (12) step(24'h0);

        // MASK=ch0 only: an edge on ch1 is ignored
        wb_write(8'h04, 32'h0000_0001);
        wb_write(8'h00, 32'h0001_0001);
        for (int c = 0; c < 8; c++) begin
            step(c == 0 ? 24'h2 : 24'h0);
            chk($sformatf("mask_trig_c%0d", c), 32'(trig_o), 32'd0);
            chk($sformatf("mask_str_c%0d", c), 32'(stretched), 32'd0);
        end
        // FORCE: fires 3 cycles after the ack cycle
        wb_write(8'h00, 32'h0001_0003);
        for (int c = 1; c < 6; c++) begin
            step(24'h0);
            chk($sformatf("force_ack+%0d", c), 32'(trig_o), 32'(c == 3));
        end
        wb_read(8'h00, rd);  chk("force_reads_0", rd, 32'h0001_0001);

        // ENABLE=0: stretchers stay live, but there is no trigger
        wb_write(8'h04, 32'h00FF_FFFF);
        wb_write(8'h00, 32'h0001_0000);
        step(24'h3);
        chk("dis_stretched", 32'(stretched), 32'h3);
        chk("dis_trig_c0", 32'(trig_o), 32'd0);
        for (int c = 1; c < 8; c++) begin
            step(24'h0);
            chk($sformatf("dis_trig_c%0d", c), 32'(trig_o), 32'd0);
        end

        // Reset in the middle of holdoff and of a stretch
        wb_write(8'h08, 32'd7);
        wb_write(8'h00, 32'h0001_3201);
        for (int c = 0; c <= 10; c++) begin
            step(c == 0 ? 24'h1 : (c == 8 ? 24'h10 : 24'h0));
            chk($sformatf("pre_rst_c%0d", c), 32'(trig_o), 32'(c == 3));
        end
        chk("pre_rst_stretched", 32'(stretched), 32'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_trig_o", 32'(trig_o), 32'd0);
        chk("mid_rst_stretched", 32'(stretched), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        wb_read(8'h00, rd);
        chk("post_rst_ctrl_lo", 32'(rd[15:0]), 32'd0);
        chk("post_rst_maj", 32'(rd[20:16]), 32'd1);
        wb_read(8'h0C, rd);  chk("post_rst_trigcnt", rd, 32'd0);
        wb_read(8'h08, rd);  chk("post_rst_stretch", rd, 32'd0);
        for (int c = 0; c < 6; c++) begin
            step(24'h0);
            chk($sformatf("post_rst_trig_c%0d", c), 32'(trig_o), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
